// File: rtl/burst_ram_arbiter_pkg.sv
// Shared state encoding and sizing helpers for the BurstRAM burst arbiter.
package burst_ram_arbiter_pkg;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_OFFER = 3'd1,
        ST_WRITE = 3'd2,
        ST_READ  = 3'd3,
        ST_DONE  = 3'd4
    } arb_state_t;

    // Bits needed to hold a beat count in the range 0..burst_count.
    function automatic int beat_cnt_width(input int burst_count);
        return (burst_count < 1) ? 1 : $clog2(burst_count + 1);
    endfunction

endpackage

// File: rtl/burst_ram_arbiter_rr_picker.sv
// Combinational round-robin select: first requester after last_served, wrapping.
module rr_picker #(
    parameter int N     = 2,
    parameter int IDX_W = (N > 1) ? $clog2(N) : 1
) (
    input  logic [N-1:0]     req,
    input  logic [IDX_W-1:0] last_served,
    output logic             valid,
    output logic [IDX_W-1:0] idx
);

    // Rotation distance of channel i from the slot just after last_served.
    function automatic int rr_dist(input int i, input int last);
        return (i + N - 1 - last) % N;
    endfunction

    // Keep the requester with the smallest rotation distance.
    always_comb begin
        int best_d;
        best_d = N;
        idx    = '0;
        for (int i = 0; i < N; i++) begin
            idx    = (req[i] && (rr_dist(i, int'(last_served)) < best_d)) ? IDX_W'(i) : idx;
            best_d = (req[i] && (rr_dist(i, int'(last_served)) < best_d)) ?
                     rr_dist(i, int'(last_served)) : best_d;
        end
        valid = |req;
    end

endmodule

// File: rtl/burst_ram_arbiter.sv
// Round-robin sharing of one BurstRAM port among burst masters, one whole burst per grant.
module burst_ram_arbiter
    import burst_ram_arbiter_pkg::*;
#(
    parameter int NUM_CHANNELS = 2,
    parameter int ADDR_WIDTH   = 14,
    parameter int DATA_WIDTH   = 64,
    parameter int BURST_COUNT  = 4
) (
    input  logic                                  clk,
    input  logic                                  rst,
    input  logic [NUM_CHANNELS-1:0]               ch_req,
    input  logic [NUM_CHANNELS-1:0]               ch_cmd,
    input  logic [NUM_CHANNELS-1:0]               ch_cmd_en,
    input  logic [NUM_CHANNELS*ADDR_WIDTH-1:0]    ch_addr,
    input  logic [NUM_CHANNELS*DATA_WIDTH-1:0]    ch_wr_data,
    input  logic [NUM_CHANNELS*DATA_WIDTH/8-1:0]  ch_data_mask,
    output logic [DATA_WIDTH-1:0]                 ch_rd_data,
    output logic [NUM_CHANNELS-1:0]               ch_rd_data_valid,
    output logic [NUM_CHANNELS-1:0]               ch_busy,
    output logic                                  br_cmd,
    output logic                                  br_cmd_en,
    output logic [ADDR_WIDTH-1:0]                 br_addr,
    output logic [DATA_WIDTH-1:0]                 br_wr_data,
    output logic [DATA_WIDTH/8-1:0]               br_data_mask,
    input  logic [DATA_WIDTH-1:0]                 br_rd_data,
    input  logic                                  br_rd_data_valid,
    input  logic                                  br_busy
);

    localparam int IDX_W  = (NUM_CHANNELS > 1) ? $clog2(NUM_CHANNELS) : 1;
    localparam int CNT_W  = beat_cnt_width(BURST_COUNT);
    localparam int MASK_W = DATA_WIDTH / 8;

    arb_state_t       state_r, state_s;
    logic [IDX_W-1:0] grant_r, grant_s;
    logic [IDX_W-1:0] last_r, last_s;
    logic [CNT_W-1:0] cnt_r, cnt_s;
    logic             pick_valid_s;
    logic [IDX_W-1:0] pick_idx_s;

    rr_picker #(
        .N     (NUM_CHANNELS),
        .IDX_W (IDX_W)
    ) u_picker (
        .req         (ch_req),
        .last_served (last_r),
        .valid       (pick_valid_s),
        .idx         (pick_idx_s)
    );

    // Data path is a pure mux of the granted channel so no latency is added.
    assign br_cmd       = ch_cmd[grant_r];
    assign br_addr      = ch_addr[grant_r*ADDR_WIDTH +: ADDR_WIDTH];
    assign br_wr_data   = ch_wr_data[grant_r*DATA_WIDTH +: DATA_WIDTH];
    assign br_data_mask = ch_data_mask[grant_r*MASK_W +: MASK_W];
    assign ch_rd_data   = br_rd_data;

    // Arbiter state registers.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_r <= ST_IDLE;
            grant_r <= '0;
            last_r  <= IDX_W'(NUM_CHANNELS - 1);
            cnt_r   <= '0;
        end else begin
            state_r <= state_s;
            grant_r <= grant_s;
            last_r  <= last_s;
            cnt_r   <= cnt_s;
        end
    end

    // Next-state: grant, offer the command slot, then count out the burst.
    always_comb begin
        state_s = state_r;
        grant_s = grant_r;
        last_s  = last_r;
        cnt_s   = cnt_r;
        case (state_r)
            ST_IDLE: begin
                if (!br_busy && pick_valid_s) begin
                    grant_s = pick_idx_s;
                    state_s = ST_OFFER;
                end else begin
                    state_s = ST_IDLE;
                end
            end
            ST_OFFER: begin
                if (ch_cmd_en[grant_r]) begin
                    if (ch_cmd[grant_r]) begin
                        // The command cycle carries the first write beat.
                        cnt_s   = CNT_W'(BURST_COUNT - 1);
                        state_s = (BURST_COUNT == 1) ? ST_DONE : ST_WRITE;
                    end else begin
                        cnt_s   = CNT_W'(BURST_COUNT);
                        state_s = ST_READ;
                    end
                end else if (!ch_req[grant_r]) begin
                    state_s = ST_IDLE;
                end else begin
                    state_s = ST_OFFER;
                end
            end
            ST_WRITE: begin
                cnt_s   = cnt_r - CNT_W'(1);
                state_s = (cnt_r == CNT_W'(1)) ? ST_DONE : ST_WRITE;
            end
            ST_READ: begin
                if (br_rd_data_valid) begin
                    cnt_s   = cnt_r - CNT_W'(1);
                    state_s = (cnt_r == CNT_W'(1)) ? ST_DONE : ST_READ;
                end else begin
                    state_s = ST_READ;
                end
            end
            ST_DONE: begin
                last_s  = grant_r;
                state_s = ST_IDLE;
            end
            default: begin
                state_s = ST_IDLE;
            end
        endcase
    end

    // Per-channel handshake and command strobe gating.
    always_comb begin
        br_cmd_en        = 1'b0;
        ch_rd_data_valid = '0;
        ch_busy          = '1;
        case (state_r)
            ST_OFFER: begin
                br_cmd_en        = ch_cmd_en[grant_r];
                ch_busy[grant_r] = 1'b0;
            end
            ST_WRITE: begin
                br_cmd_en = ch_cmd_en[grant_r];
            end
            ST_READ: begin
                ch_rd_data_valid[grant_r] = br_rd_data_valid;
            end
            default: begin
                br_cmd_en = 1'b0;
            end
        endcase
    end

endmodule

// File: tb/tb_burst_ram_arbiter.sv
// Directed self-checking bench for burst_ram_arbiter with a small BurstRAM model (read latency 3).
module tb_burst_ram_arbiter;

    logic         clk;
    logic         rst;
    logic [1:0]   ch_req, ch_cmd, ch_cmd_en;
    logic [27:0]  ch_addr;
    logic [127:0] ch_wr_data;
    logic [15:0]  ch_data_mask;
    logic [63:0]  ch_rd_data;
    logic [1:0]   ch_rd_data_valid, ch_busy;
    logic         br_cmd, br_cmd_en;
    logic [13:0]  br_addr;
    logic [63:0]  br_wr_data;
    logic [7:0]   br_data_mask;
    logic [63:0]  br_rd_data;
    logic         br_rd_data_valid, br_busy;

    int total, bad, n, stray;
    logic         gap_en;
    logic [63:0]  mem [0:511];
    logic [63:0]  rbuf [0:31];
    logic [13:0]  rd_base;
    int           rd_wait, rd_left, rd_k, wbeat;
    logic         gap_done;

    burst_ram_arbiter dut (
        .clk (clk), .rst (rst),
        .ch_req (ch_req), .ch_cmd (ch_cmd), .ch_cmd_en (ch_cmd_en),
        .ch_addr (ch_addr), .ch_wr_data (ch_wr_data), .ch_data_mask (ch_data_mask),
        .ch_rd_data (ch_rd_data), .ch_rd_data_valid (ch_rd_data_valid), .ch_busy (ch_busy),
        .br_cmd (br_cmd), .br_cmd_en (br_cmd_en), .br_addr (br_addr),
        .br_wr_data (br_wr_data), .br_data_mask (br_data_mask),
        .br_rd_data (br_rd_data), .br_rd_data_valid (br_rd_data_valid), .br_busy (br_busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [63:0] pat(input int a);
        return 64'hFACE_0000_0000_0000 | 64'(a);
    endfunction

    // BurstRAM model: writes one beat per forwarded strobe, reads return 4 beats after 3 cycles.
    always @(posedge clk or negedge rst) begin
        if (!rst) begin
            br_rd_data_valid <= 1'b0;
            br_rd_data       <= 64'd0;
            rd_base <= 14'd0; rd_wait <= 0; rd_left <= 0; rd_k <= 0; wbeat <= 0;
            gap_done <= 1'b0;
        end else begin
            br_rd_data_valid <= 1'b0;
            if (br_cmd_en && br_cmd) begin
                mem[int'(br_addr[8:0]) + wbeat] <= br_wr_data;
                wbeat <= (wbeat == 3) ? 0 : wbeat + 1;
            end
            if (br_cmd_en && !br_cmd) begin
                rd_base <= br_addr; rd_wait <= 2; rd_left <= 4; rd_k <= 0; gap_done <= 1'b0;
            end else if (rd_left != 0) begin
                if (rd_wait != 0) begin
                    rd_wait <= rd_wait - 1;
                end else if (gap_en && rd_k == 2 && !gap_done) begin
                    gap_done <= 1'b1;
                end else begin
                    br_rd_data_valid <= 1'b1;
                    br_rd_data       <= pat(int'(rd_base) + rd_k);
                    rd_k    <= rd_k + 1;
                    rd_left <= rd_left - 1;
                end
            end
        end
    end

    task automatic cyc(input int k);
        repeat (k) @(posedge clk);
        #2;
    endtask

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic await_grant(input int ch, input string tag);
        for (int t = 0; t < 12 && ch_busy == 2'b11; t++) cyc(1);
        chk(tag, ch_busy, 128'(2'b11 & ~(2'b01 << ch)));
    endtask

    task automatic issue(input int ch, input logic wr, input logic [13:0] addr);
        ch_cmd[ch] = wr;
        ch_addr[ch*14 +: 14] = addr;
        ch_cmd_en = 2'b00;
        ch_cmd_en[ch] = 1'b1;
        #1;
        chk("cmd_fwd", {br_cmd_en, br_cmd, br_addr}, {1'b1, wr, addr});
    endtask

    task automatic wr_burst(input int ch, input logic [13:0] addr, input logic [63:0] base);
        ch_data_mask[ch*8 +: 8] = 8'hFF;
        ch_wr_data[ch*64 +: 64] = base;
        ch_wr_data[(1-ch)*64 +: 64] = 64'hDEAD_BEEF_0000_0000;
        issue(ch, 1'b1, addr);
        chk("wr_beat0", {br_data_mask, br_wr_data}, {8'hFF, base});
        for (int k = 1; k < 4; k++) begin
            cyc(1);
            ch_wr_data[ch*64 +: 64] = base + 64'(k);
            #1;
            chk("wr_beat", {br_cmd_en, br_wr_data}, {1'b1, base + 64'(k)});
        end
        cyc(1);
        chk("done_no_fwd", br_cmd_en, 128'd0);
        ch_cmd_en = 2'b00;
    endtask

    task automatic count_rd(input int ch, input int stop_at, output int cnt, output int other);
        cnt = 0;
        other = 0;
        for (int t = 0; t < 20 && cnt < stop_at; t++) begin
            cyc(1);
            if (ch_rd_data_valid[ch]) begin
                rbuf[cnt] = ch_rd_data;
                cnt++;
            end
            if (ch_rd_data_valid[1-ch]) other++;
        end
    endtask

    initial begin
        total = 0; bad = 0;
        rst = 1'b0; br_busy = 1'b0; gap_en = 1'b0;
        ch_req = 2'b00; ch_cmd = 2'b00; ch_cmd_en = 2'b00;
        ch_addr = '0; ch_wr_data = '0; ch_data_mask = '0;

        // Reset and idle
        #3;
        chk("rst_busy", ch_busy, 128'd3);
        chk("rst_cmd_en", br_cmd_en, 128'd0);
        chk("rst_rvalid", ch_rd_data_valid, 128'd0);
        cyc(1);
        rst = 1'b1;
        cyc(3);
        chk("idle_busy", ch_busy, 128'd3);
        br_busy = 1'b1; ch_req = 2'b01;
        cyc(2);
        chk("br_busy_hold", ch_busy, 128'd3);

        // Ch0 read of 4 beats at 0x10
        br_busy = 1'b0;
        cyc(1);
        chk("grant0_lat", ch_busy, 128'd2);
        issue(0, 1'b0, 14'h010);
        cyc(1);
        ch_cmd_en = 2'b00; ch_req = 2'b00;
        count_rd(0, 99, n, stray);
        chk("rd0_beats", n, 128'd4);
        chk("rd0_stray", stray, 128'd0);
        chk("rd0_first", rbuf[0], pat(16));
        chk("rd0_last", rbuf[3], pat(19));

        // Ch1 write of 0xA..0xD at 0x20
        ch_req = 2'b10;
        cyc(1);
        chk("grant1", ch_busy, 128'd1);
        wr_burst(1, 14'h020, 64'hA);
        ch_req = 2'b00;
        cyc(1);
        chk("mem_wr", {mem[32][7:0], mem[33][7:0], mem[34][7:0], mem[35][7:0]}, 128'h0A0B0C0D);

        // Both channels requesting: grants alternate
        ch_req = 2'b11;
        for (int b = 0; b < 6; b++) begin
            await_grant(b % 2, "alt_grant");
            wr_burst(b % 2, 14'h040 + 14'(b*4), 64'h100 + 64'(b*16));
        end
        ch_req = 2'b00;
        cyc(2);

        // Ch1 abandons its offer; its priority survives
        ch_req = 2'b01;
        await_grant(0, "solo0");
        wr_burst(0, 14'h080, 64'h200);
        ch_req = 2'b00;
        cyc(2);
        ch_req = 2'b10;
        await_grant(1, "offer1");
        ch_req = 2'b00; ch_cmd_en = 2'b01; ch_cmd[0] = 1'b1;
        #1;
        chk("abort_no_cmd", br_cmd_en, 128'd0);
        ch_cmd_en = 2'b00;
        cyc(1);
        chk("abort_idle", ch_busy, 128'd3);
        ch_req = 2'b11;
        await_grant(1, "prio_kept");
        gap_en = 1'b1;
        issue(1, 1'b0, 14'h010);
        cyc(1);
        ch_cmd_en = 2'b00; ch_req[1] = 1'b0;
        ch_cmd[0] = 1'b1; ch_cmd_en[0] = 1'b1;
        #1;
        chk("foreign_cmd", br_cmd_en, 128'd0);
        ch_cmd_en = 2'b00; ch_req[0] = 1'b0;
        count_rd(1, 99, n, stray);
        chk("rd1_gap_beats", n, 128'd4);
        chk("rd1_stray", stray, 128'd0);
        chk("rd1_last", rbuf[3], pat(19));
        gap_en = 1'b0;

        // Reset in the middle of a read
        ch_req = 2'b01;
        await_grant(0, "pre_rst_grant");
        issue(0, 1'b0, 14'h010);
        cyc(1);
        ch_cmd_en = 2'b00;
        count_rd(0, 2, n, stray);
        chk("two_beats", n, 128'd2);
        rst = 1'b0;
        #1;
        chk("mid_rst_busy", ch_busy, 128'd3);
        chk("mid_rst_rvalid", ch_rd_data_valid, 128'd0);
        chk("mid_rst_cmd_en", br_cmd_en, 128'd0);
        cyc(2);
        chk("rst_hold_busy", ch_busy, 128'd3);
        rst = 1'b1;
        cyc(1);
        chk("post_rst_grant", ch_busy, 128'd2);
        issue(0, 1'b0, 14'h010);
        cyc(1);
        ch_cmd_en = 2'b00; ch_req = 2'b00;
        count_rd(0, 99, n, stray);
        chk("post_rst_beats", n, 128'd4);
        chk("post_rst_first", rbuf[0], pat(16));

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/burst_ram_arbiter.md
Name: burst_ram_arbiter

Overview:
- Shares one BurstRAM command/data port among NUM_CHANNELS burst masters (instruction cache, data cache, future DMA).
- Sits between the masters and BurstRAM inside SoC.
- Masters keep the BurstRAM-style interface plus a level request line.
- Arbitration is round-robin, one whole burst (command plus BURST_COUNT beats) per grant, with zero added latency on the forwarded data path.

Parameters:
NUM_CHANNELS, 2, number of master channels (1..8)
ADDR_WIDTH, 14, BurstRAM address width (2^ADDR_WIDTH x DATA_WIDTH/8 bytes)
DATA_WIDTH, 64, beat width; mask width is DATA_WIDTH/8
BURST_COUNT, 4, beats per read or write burst (>=1)

Ports:
clk  in  1  system clock
rst  in  1  asynchronous reset, active-low
ch_req  in  NUM_CHANNELS  level request; held until the channel's burst completes
ch_cmd  in  NUM_CHANNELS  per channel: 1=write, 0=read
ch_cmd_en  in  NUM_CHANNELS  per channel command strobe; legal only while that channel's ch_busy=0
ch_addr  in  NUM_CHANNELS*ADDR_WIDTH  flattened addresses, channel i at [i*ADDR_WIDTH +: ADDR_WIDTH]
ch_wr_data  in  NUM_CHANNELS*DATA_WIDTH  flattened write beats
ch_data_mask  in  NUM_CHANNELS*DATA_WIDTH/8  flattened byte masks
ch_rd_data  out  DATA_WIDTH  read beat, broadcast to all channels
ch_rd_data_valid  out  NUM_CHANNELS  read beat valid, granted channel only
ch_busy  out  NUM_CHANNELS  1 = channel may not issue a command
br_cmd, br_cmd_en  out  1 each  to BurstRAM
br_addr  out  ADDR_WIDTH  to BurstRAM
br_wr_data  out  DATA_WIDTH  to BurstRAM
br_data_mask  out  DATA_WIDTH/8  to BurstRAM
br_rd_data  in  DATA_WIDTH  from BurstRAM
br_rd_data_valid, br_busy  in  1 each  from BurstRAM

Behaviour:
- Registered state: state, grant index, last-served pointer, beat counter (clog2(BURST_COUNT+1) bits).
- Reset (rst=0, async):
  - state=IDLE, last-served=NUM_CHANNELS-1, counter=0.
  - All ch_busy=1, ch_rd_data_valid=0, br_cmd_en=0.
- br_cmd/br_addr/br_wr_data/br_data_mask: combinational mux of the granted channel.
- br_cmd_en = ch_cmd_en[grant] only in OFFER or WRITE, else 0. A ch_cmd_en from a non-granted channel is ignored.
- ch_rd_data = br_rd_data always.
- ch_rd_data_valid[grant] = br_rd_data_valid only in READ, else 0.
- ch_busy[i] = 0 only when state==OFFER and grant==i.
- IDLE:
  - If br_busy==0 and any ch_req: pick the first requester scanning last-served+1 upward with wrap; register grant; go to OFFER next cycle.
  - Otherwise stay in IDLE.
- OFFER:
  - ch_cmd_en[grant]=1 with cmd=1: forward; counter=BURST_COUNT-1; go to WRITE, or straight to DONE if BURST_COUNT==1.
  - ch_cmd_en[grant]=1 with cmd=0: forward; counter=BURST_COUNT; go to READ.
  - ch_req[grant] dropped with no cmd_en: go to IDLE; last-served is NOT updated.
- WRITE:
  - One beat per cycle from the granted channel's ch_wr_data/ch_data_mask.
  - Decrement counter each cycle; at 0 go to DONE.
- READ:
  - Decrement counter on each br_rd_data_valid; at the last valid beat go to DONE.
  - Beats with br_rd_data_valid=0 are not counted, so gaps are tolerated.
- DONE: last-served=grant, then IDLE next cycle. IDLE's br_busy check prevents issuing before BurstRAM recovers.
- Fairness: a requesting channel waits at most NUM_CHANNELS-1 bursts.
- Simultaneous requests: resolved strictly by the rotation order. A new request arriving in DONE is considered in the following IDLE.
- ch_req deasserted mid-burst: ignored; the burst completes.
- NUM_CHANNELS==1: degenerates to a pass-through with a one-cycle OFFER per burst.
- Reset asserted mid-burst: immediate return to IDLE. BurstRAM is reset from the same source, so no partial-burst recovery is needed.

Decomposition:
- Package burst_ram_arbiter_pkg:
  - state encoding IDLE/OFFER/WRITE/READ/DONE;
  - beat-counter width function.
- One sub-module, rr_picker: combinational round-robin priority select.
  - Inputs: req vector, last-served index.
  - Outputs: valid, index.
  - Reused later by the UART/DMA bus arbiter.

Test Plan:
- Reset, then idle: all ch_busy=1, br_cmd_en=0, ch_rd_data_valid=0; release rst with no ch_req -> state stays IDLE, ch_busy stays 1.
- Ch0 read at addr 0x10, BURST_COUNT=4, RAM model latency 3: ch_busy[0]=0 one cycle after req; br_addr=0x10 with br_cmd_en=1; exactly 4 ch_rd_data_valid[0] pulses; ch_rd_data_valid[1]=0 throughout.
- Ch1 write of beats 0xA..0xD, mask 0xFF: br_wr_data equals 0xA,0xB,0xC,0xD on 4 consecutive cycles; memory model holds them at addr..addr+3.
- Both channels requesting continuously, 6 bursts: grants alternate 0,1,0,1,0,1; neither channel waits more than one burst.
- Ch1 drops ch_req during OFFER: no br_cmd_en is issued, and ch1 still holds priority on its next request; in addition, a cmd_en from non-granted ch0 during ch1's READ is not forwarded.
- rst asserted mid-read, after the 2nd beat: outputs return to their reset values asynchronously; after release a fresh ch0 read completes with 4 beats.
